// File: rtl/btn_event_conditioner_if.sv
`default_nettype none
// ============================================================================
// btn_event_conditioner_if : press-event valid/ready handshake bundle
// Revision: 1.0
// ============================================================================
interface btn_event_conditioner_if #(
    parameter int IDX_W = 2
);
    logic             press_valid;
    logic [IDX_W-1:0] press_idx;
    logic             press_ready;

    modport master (output press_valid, output press_idx, input press_ready);
    modport slave  (input press_valid, input press_idx, output press_ready);
endinterface
`default_nettype wire

// File: rtl/btn_event_conditioner.sv
`default_nettype none
// ============================================================================
// btn_event_conditioner : sync + debounce + edge-detect buttons, queue presses
// Optional macro AUTO_REPEAT_EN adds hold-to-repeat presses. Revision: 1.0
// ============================================================================
module btn_event_conditioner #(
    parameter int NUM_BTNS        = 4,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 12500000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic                ena,
    input  wire logic [NUM_BTNS-1:0] btn_raw,
    output logic      [NUM_BTNS-1:0] btn_level,
    btn_event_conditioner_if.master  evt,
    output logic      [7:0]          drop_cnt
);
    localparam int IDX_W = (NUM_BTNS > 1) ? $clog2(NUM_BTNS) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_BTNS-1:0] r_sync1;
    logic [NUM_BTNS-1:0] r_sync2;
    logic [NUM_BTNS-1:0] r_level;
    logic [NUM_BTNS-1:0] r_pend;
    logic                r_valid;
    logic [IDX_W-1:0]    r_idx;
    logic [7:0]          r_drop;

    logic [NUM_BTNS-1:0] w_flip;
    logic [NUM_BTNS-1:0] w_rise;
    logic [NUM_BTNS-1:0] w_repeat;
    logic [NUM_BTNS-1:0] w_accept;
    logic [NUM_BTNS-1:0] w_clr;
    logic [NUM_BTNS-1:0] w_drop;
    logic [IDX_W-1:0]    w_pick;
    logic                w_any;
    logic                w_load;
    logic [3:0]          w_drop_n;
    logic [8:0]          w_drop_sum;

    // Synchroniser and debounced level register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_level <= '0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
            r_level <= r_level ^ w_flip;
        end
    end

    for (genvar g = 0; g < NUM_BTNS; g++) begin : g_chan
        logic [CNT_W-1:0] r_cnt;
        logic             w_mismatch;

        assign w_mismatch = r_sync2[g] ^ r_level[g];
        assign w_flip[g]  = w_mismatch && (r_cnt == CNT_MAX);
        assign w_rise[g]  = w_flip[g] & r_sync2[g];

        always_ff @(posedge clk) begin
            if (rst || !w_mismatch || w_flip[g]) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam int HOLD_MAXV = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HOLD_W    = $clog2(HOLD_MAXV + 1);
    localparam logic [HOLD_W-1:0] DLY_MAX = HOLD_W'(REPEAT_DELAY - 1);
    localparam logic [HOLD_W-1:0] PER_MAX = HOLD_W'(REPEAT_PERIOD - 1);

    for (genvar g = 0; g < NUM_BTNS; g++) begin : g_repeat
        logic [HOLD_W-1:0] r_hold;
        logic              r_rep;

        // First repeat after the initial delay, then at the shorter period
        assign w_repeat[g] = r_level[g] && (r_hold == (r_rep ? PER_MAX : DLY_MAX));

        always_ff @(posedge clk) begin
            if (rst || !r_level[g]) begin
                r_hold <= '0;
                r_rep  <= 1'b0;
            end else if (w_repeat[g]) begin
                r_hold <= '0;
                r_rep  <= 1'b1;
            end else begin
                r_hold <= r_hold + 1'b1;
            end
        end
    end
`else
    assign w_repeat = '0;
`endif

    // Lowest pending channel wins the output slot
    always_comb begin
        w_any  = |r_pend;
        w_pick = '0;
        for (int i = NUM_BTNS - 1; i >= 0; i--) begin
            if (r_pend[i]) begin
                w_pick = IDX_W'(i);
            end
        end
    end

    assign w_load   = !r_valid || evt.press_ready;
    assign w_clr    = (w_load && w_any) ? (NUM_BTNS'(1) << w_pick) : '0;
    assign w_accept = (w_rise | w_repeat) & {NUM_BTNS{ena}};
    assign w_drop   = w_accept & r_pend & ~w_clr;

    always_comb begin
        w_drop_n = '0;
        for (int i = 0; i < NUM_BTNS; i++) begin
            w_drop_n = w_drop_n + {3'b000, w_drop[i]};
        end
        w_drop_sum = {1'b0, r_drop} + {5'b00000, w_drop_n};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend  <= '0;
            r_valid <= 1'b0;
            r_idx   <= '0;
            r_drop  <= '0;
        end else begin
            // A new press on the channel being drained sets it again
            r_pend <= (r_pend & ~w_clr) | w_accept;
            if (w_load) begin
                r_valid <= w_any;
                if (w_any) begin
                    r_idx <= w_pick;
                end
            end
            r_drop <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
        end
    end

    assign btn_level       = r_level;
    assign evt.press_valid = r_valid;
    assign evt.press_idx   = r_idx;
    assign drop_cnt        = r_drop;
endmodule
`default_nettype wire

// File: tb/tb_btn_event_conditioner.sv
`default_nettype none
// ============================================================================
// tb_btn_event_conditioner : directed self-checking bench, NUM_BTNS=4, DEBOUNCE_CYCLES=4
// Revision: 1.0
// ============================================================================
module tb_btn_event_conditioner;
    logic       clk;
    logic       rst;
    logic       ena;
    logic [3:0] btn_raw;
    logic [3:0] btn_level;
    logic [7:0] drop_cnt;
    int         checks;
    int         passes;

    btn_event_conditioner_if #(.IDX_W(2)) evt ();

    btn_event_conditioner #(
        .NUM_BTNS       (4),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .btn_raw  (btn_raw),
        .btn_level(btn_level),
        .evt      (evt),
        .drop_cnt (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        checks = 0;
        passes = 0;
        rst = 1'b1;
        ena = 1'b1;
        btn_raw = 4'b0000;
        evt.press_ready = 1'b1;
        step(2);
        chk("rst_level", 32'(btn_level), 32'h0);
        chk("rst_valid", 32'(evt.press_valid), 32'h0);
        chk("rst_idx", 32'(evt.press_idx), 32'h0);
        chk("rst_drop", 32'(drop_cnt), 32'h0);
        rst = 1'b0;
        step(3);
        chk("idle_valid", 32'(evt.press_valid), 32'h0);

        // Debounce latency on channel 1
        btn_raw = 4'b0010;
        for (int k = 1; k <= 8; k++) begin
            step(1);
            chk("lat_level1", 32'(btn_level[1]), 32'(k >= 6));
            chk("lat_valid", 32'(evt.press_valid), 32'(k == 7));
            if (k == 7) chk("lat_idx", 32'(evt.press_idx), 32'h1);
        end
        btn_raw = 4'b0000;
        step(10);
        chk("rel_level", 32'(btn_level), 32'h0);
        chk("rel_valid", 32'(evt.press_valid), 32'h0);

        // 3-cycle glitch on channel 0 is rejected
        btn_raw = 4'b0001;
        step(3);
        btn_raw = 4'b0000;
        for (int k = 1; k <= 8; k++) begin
            step(1);
            chk("glitch_level0", 32'(btn_level[0]), 32'h0);
            chk("glitch_valid", 32'(evt.press_valid), 32'h0);
        end

        // Simultaneous presses delivered lowest index first
        btn_raw = 4'b1101;
        step(6);
        chk("prio_level", 32'(btn_level), 32'hD);
        chk("prio_valid0", 32'(evt.press_valid), 32'h0);
        step(1);
        chk("prio_v_a", 32'(evt.press_valid), 32'h1);
        chk("prio_idx_a", 32'(evt.press_idx), 32'h0);
        step(1);
        chk("prio_v_b", 32'(evt.press_valid), 32'h1);
        chk("prio_idx_b", 32'(evt.press_idx), 32'h2);
        step(1);
        chk("prio_v_c", 32'(evt.press_valid), 32'h1);
        chk("prio_idx_c", 32'(evt.press_idx), 32'h3);
        step(1);
        chk("prio_v_end", 32'(evt.press_valid), 32'h0);
        btn_raw = 4'b0000;
        step(10);

        // Backpressure: slot held, one pending, third press dropped
        evt.press_ready = 1'b0;
        btn_raw = 4'b0100;
        step(7);
        chk("bp_valid1", 32'(evt.press_valid), 32'h1);
        chk("bp_idx1", 32'(evt.press_idx), 32'h2);
        btn_raw = 4'b0000;
        step(8);
        chk("bp_hold_valid", 32'(evt.press_valid), 32'h1);
        chk("bp_hold_idx", 32'(evt.press_idx), 32'h2);
        chk("bp_level2", 32'(btn_level[2]), 32'h0);
        btn_raw = 4'b0100;
        step(8);
        chk("bp_drop0", 32'(drop_cnt), 32'h0);
        btn_raw = 4'b0000;
        step(8);
        btn_raw = 4'b0100;
        step(8);
        chk("bp_drop1", 32'(drop_cnt), 32'h1);
        chk("bp_valid3", 32'(evt.press_valid), 32'h1);
        chk("bp_idx3", 32'(evt.press_idx), 32'h2);
        evt.press_ready = 1'b1;
        step(1);
        chk("bp_next_valid", 32'(evt.press_valid), 32'h1);
        chk("bp_next_idx", 32'(evt.press_idx), 32'h2);
        step(1);
        chk("bp_empty", 32'(evt.press_valid), 32'h0);
        step(3);
        chk("bp_empty2", 32'(evt.press_valid), 32'h0);
        chk("bp_drop_keep", 32'(drop_cnt), 32'h1);
        btn_raw = 4'b0000;
        step(10);

        // ena low: press on channel 3 is discarded, no drop
        ena = 1'b0;
        btn_raw = 4'b1000;
        for (int k = 1; k <= 9; k++) begin
            step(1);
            chk("ena_valid", 32'(evt.press_valid), 32'h0);
        end
        chk("ena_level3", 32'(btn_level[3]), 32'h1);
        chk("ena_drop", 32'(drop_cnt), 32'h1);
        ena = 1'b1;
        step(5);
        chk("ena_late_valid", 32'(evt.press_valid), 32'h0);
        btn_raw = 4'b0000;
        step(10);

        // Reset mid-operation with slot full and pending=0101
        evt.press_ready = 1'b0;
        btn_raw = 4'b0010;
        step(8);
        chk("mr_valid", 32'(evt.press_valid), 32'h1);
        chk("mr_idx", 32'(evt.press_idx), 32'h1);
        btn_raw = 4'b0111;
        step(8);
        chk("mr_level", 32'(btn_level), 32'h7);
        chk("mr_valid2", 32'(evt.press_valid), 32'h1);
        rst = 1'b1;
        btn_raw = 4'b0001;
        evt.press_ready = 1'b1;
        step(1);
        rst = 1'b0;
        chk("mr_rst_level", 32'(btn_level), 32'h0);
        chk("mr_rst_valid", 32'(evt.press_valid), 32'h0);
        chk("mr_rst_idx", 32'(evt.press_idx), 32'h0);
        chk("mr_rst_drop", 32'(drop_cnt), 32'h0);
        for (int k = 1; k <= 9; k++) begin
            step(1);
            chk("mr_post_valid", 32'(evt.press_valid), 32'(k == 7));
            if (k == 7) chk("mr_post_idx", 32'(evt.press_idx), 32'h0);
            if (k == 6) chk("mr_post_level", 32'(btn_level), 32'h1);
        end
        btn_raw = 4'b0000;
        step(10);

`ifdef AUTO_REPEAT_EN
        // Hold channel 1: real press, then repeats 10 and 15 cycles after it
        btn_raw = 4'b0010;
        for (int k = 1; k <= 25; k++) begin
            step(1);
            chk("rep_valid", 32'(evt.press_valid), 32'((k == 7) || (k == 17) || (k == 22)));
        end
        btn_raw = 4'b0000;
        step(10);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
`default_nettype wire
